div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_pkg.sv | 37 +++
 rtl/div_step.sv | 28 ++
 rtl/div_ctrl.sv | 148 ++++++++++++++
 tb/tb_div_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

  // Fixed results for divide-by-zero and signed overflow (0x80000000 / -1).
  function automatic logic [XLEN-1:0] special_result(input logic is_rem,
                                                     input logic div0,
                                                     input logic [XLEN-1:0] op_a);
    if (div0) return is_rem ? op_a : '1;
    return is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dq_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] dq_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The shifted remainder keeps rem_i[XLEN-1] so divisors above 2^31 compare correctly.
  always_comb begin
    shifted = {rem_i, dq_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      dq_o  = {dq_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      dq_o  = {dq_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative 32-bit signed/unsigned divider controller (IDLE/CALC/DONE).
// Define DIV_FAST_SPECIAL_EN to let divide-by-zero and signed overflow skip CALC.
module div_ctrl
  import div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy
);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dq_q, dq_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] data_q, data_d;
  div_op_e         op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_q_q, sign_q_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;

  logic [XLEN-1:0] step_rem, step_dq;
  logic            hs;
  div_op_e         in_op;
  logic            in_signed, in_div0, in_ovf;
  logic [XLEN-1:0] q_fix, r_fix, result;

  div_step u_step (
    .rem_i     (rem_q),
    .dq_i      (dq_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .dq_o      (step_dq)
  );

  assign hs        = i_valid && (state_q == IDLE) && !i_flush;
  assign in_op     = div_op_e'(i_op);
  assign in_signed = op_is_signed(in_op);
  assign in_div0   = (i_op_b == '0);
  assign in_ovf    = in_signed && (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_op_b == '1);

  always_comb begin
    q_fix  = (op_is_signed(op_q) && sign_q_q) ? (~step_dq + 1'b1) : step_dq;
    r_fix  = (op_is_signed(op_q) && sign_a_q) ? (~step_rem + 1'b1) : step_rem;
    result = op_is_rem(op_q) ? r_fix : q_fix;
    if (div0_q || ovf_q) result = special_result(op_is_rem(op_q), div0_q, op_a_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    op_a_d    = op_a_q;
    data_d    = data_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_q_d  = sign_q_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d   = CALC;
          cnt_d     = CNT_W'(DIV_ITER - 1);
          op_d      = in_op;
          op_a_d    = i_op_a;
          sign_a_d  = in_signed && i_op_a[XLEN-1];
          sign_q_d  = in_signed && (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
          div0_d    = in_div0;
          ovf_d     = in_ovf;
          rem_d     = '0;
          dq_d      = (in_signed && i_op_a[XLEN-1]) ? (~i_op_a + 1'b1) : i_op_a;
          divisor_d = (in_signed && i_op_b[XLEN-1]) ? (~i_op_b + 1'b1) : i_op_b;
`ifdef DIV_FAST_SPECIAL_EN
          if (in_div0 || in_ovf) begin
            state_d = DONE;
            data_d  = special_result(op_is_rem(in_op), in_div0, i_op_a);
          end
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        if (cnt_q == '0) begin
          state_d = DONE;
          data_d  = result;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      divisor_q <= '0;
      op_a_q    <= '0;
      data_q    <= '0;
      op_q      <= DIV;
      sign_a_q  <= 1'b0;
      sign_q_q  <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      op_a_q    <= op_a_d;
      data_q    <= data_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_q_q  <= sign_q_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_data  = data_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl.
module tb_div_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_op_a = '0;
  logic [31:0] i_op_b = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_busy;

  int unsigned passed = 0;
  int unsigned total  = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  div_ctrl dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_op_a  (i_op_a),
    .i_op_b  (i_op_b),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issues one request, measures latency, optionally stalls i_ready in DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    logic [31:0] first;
    @(negedge i_clk);
    chk({tag, ".ready_before"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_op = op; i_op_a = a; i_op_b = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".data"}, o_data, exp);
    first = o_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk); #1;
      chk({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
      chk({tag, ".hold_data"}, o_data, first);
      chk({tag, ".hold_ready"}, 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk({tag, ".idle_after"}, 32'(o_ready), 32'd1);
    chk({tag, ".valid_after"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.busy",  32'(o_busy),  32'd0);
    chk("rst.data",  o_data,       32'd0);
    #20 i_rst_n = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2,  33, 0);
    run_op("div_m7_2",   2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
    run_op("rem_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
    run_op("div_7_m2",   2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
    run_op("divu_big",   2'b01, 32'hFFFFFFFF, 32'h80000001, 32'd1, 33, 0);
    run_op("remu_big",   2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33, 0);
    run_op("div_ovf",    2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT, 0);
    run_op("rem_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, SPECIAL_LAT, 0);
    run_op("div_by0",    2'b00, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT, 0);
    run_op("rem_by0",    2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, SPECIAL_LAT, 0);
    run_op("remu_by0",   2'b11, 32'd1234, 32'd0, 32'd1234, SPECIAL_LAT, 0);
    run_op("backpress",  2'b00, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFF9C, 33, 5);

    // Flush together with valid in IDLE drops the request.
    @(negedge i_clk);
    i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_op_a = 32'd50; i_op_b = 32'd5;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle.ready", 32'(o_ready), 32'd1);
    chk("flush_idle.busy",  32'(o_busy),  32'd0);

    // Flush on the 10th CALC cycle.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = 2'b01; i_op_a = 32'd1000; i_op_b = 32'd7;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) seen++;
    end
    chk("flush_calc.busy", 32'(o_busy), 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush_calc.ready", 32'(o_ready), 32'd1);
    chk("flush_calc.busy0", 32'(o_busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) seen++;
    end
    chk("flush_calc.no_valid", 32'(seen), 32'd0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 0);

    // Asynchronous reset on the 20th CALC cycle.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = 2'b01; i_op_a = 32'd77777; i_op_b = 32'd13;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(posedge i_clk); #1;
    end
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(o_valid), 32'd0);
    chk("arst.ready", 32'(o_ready), 32'd1);
    chk("arst.busy",  32'(o_busy),  32'd0);
    chk("arst.data",  o_data,       32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("remu_10_4", 2'b11, 32'd10, 32'd4, 32'd2, 33, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
